// File: rtl/seg_countdown.sv
// -----------------------------------------------------------------------------
// seg_countdown
//
// This block loads two active-low 7-segment digit patterns and decodes them
// into an 8-bit value, {high nibble, low nibble}. It then counts that value
// down to zero, one step per enabled clock. The decode table is the inverse of
// the team's binary-to-segment encoder. Any of the 112 patterns that are not
// in the table count as invalid.
//
// Ports
//   clk      in   1  rising-edge clock
//   clear_b  in   1  asynchronous active-low reset
//   load     in   1  capture seg_hi/seg_lo and (re)start a countdown
//   enable   in   1  decrement enable, used only while counting
//   seg_hi   in   7  high digit pattern, bit0 = segment a .. bit6 = segment g
//   seg_lo   in   7  low digit pattern, same encoding
//   count    out  8  current countdown value (registered)
//   busy     out  1  high while counting (decoded from the state register)
//   done     out  1  one-cycle pulse on the edge that reaches zero
//   err      out  1  sticky flag: last load held an unrecognised pattern
// -----------------------------------------------------------------------------
module seg_countdown (
    input  logic       clk,
    input  logic       clear_b,
    input  logic       load,
    input  logic       enable,
    input  logic [6:0] seg_hi,
    input  logic [6:0] seg_lo,
    output logic [7:0] count,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       done_q,  done_d;
    logic       err_q,   err_d;

    logic [4:0] hi_dec;
    logic [4:0] lo_dec;
    logic       load_ok;
    logic [7:0] load_val;

    // Returns {valid, nibble}. An unlisted pattern returns valid = 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h18:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        hi_dec   = seg_decode(seg_hi);
        lo_dec   = seg_decode(seg_lo);
        load_ok  = hi_dec[4] & lo_dec[4];
        load_val = {hi_dec[3:0], lo_dec[3:0]};
    end

    // Next-state logic. A load always wins over enable. An invalid load keeps
    // count unchanged but abandons any countdown that is in progress.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (load) begin
            if (load_ok) begin
                count_d = load_val;
                err_d   = 1'b0;
                if (load_val == 8'h00) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_COUNT;
                end
            end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (enable) begin
                        count_d = count_q - 8'd1;
                        if (count_q == 8'd1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                // Enable is ignored here, so count cannot wrap below zero.
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_COUNT);
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: doc/seg_countdown.md
SEG_COUNTDOWN -- requirements
Module: seg_countdown

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 clear_b  in  1  asynchronous active-low reset.
REQ-004 load  in  1  sample seg_hi/seg_lo on this edge and start a countdown.
REQ-005 enable  in  1  count-down enable, sampled each rising edge.
REQ-006 seg_hi  in  7  high-nibble digit pattern, bit 0 = segment a … bit 6 = segment g, active-low.
REQ-007 seg_lo  in  7  low-nibble digit pattern, same encoding.
REQ-008 count  out  8  current countdown value.
REQ-009 busy  out  1  high while in COUNT state.
REQ-010 done  out  1  one-cycle pulse on reaching zero.
REQ-011 err  out  1  sticky flag set by a load containing an unrecognised pattern.

Function
REQ-012 The digit code table SHALL be used exactly, hex digit -> 7-bit pattern: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E.
  - All values are in hex.
  - This table matches the team's existing binary-to-segment encoder.
REQ-013 Any pattern not in the table SHALL be invalid; the 112 unlisted codes are all invalid.
REQ-014 The state machine SHALL have three states, with IDLE as the reset state:
  - IDLE: not counting.
  - COUNT: counting down.
  - DONE: countdown finished.
REQ-015 When load=1 and both patterns are valid, the next edge SHALL set count = {dec(seg_hi), dec(seg_lo)} and clear err.
  - count==0 afterwards -> go to DONE and assert done.
  - count!=0 afterwards -> go to COUNT.
REQ-016 When load=1 and either pattern is invalid, the next edge SHALL set err=1 and go to IDLE.
  - count keeps its previous value.
  - busy=0.
  - done is not asserted.
REQ-017 load SHALL take priority over enable in every state.
  - A load while in COUNT restarts the countdown from the new value.
  - No decrement occurs on that edge.
REQ-018 In COUNT, with load=0 and enable=1, each edge SHALL decrement count by 1.
REQ-019 In COUNT, with load=0 and enable=0, count and state SHALL hold.
REQ-020 When a decrement takes count from 1 to 0, that edge SHALL enter DONE and assert done for exactly one cycle.
REQ-021 count SHALL never wrap from 0 to FF.
  - enable is ignored in IDLE and DONE.
REQ-022 DONE SHALL hold count=0 until the next load; a valid load from DONE behaves as in REQ-015.
REQ-023 Output latency SHALL be one clock:
  - count, busy, done and err are registered outputs.
  - busy = (state==COUNT).
REQ-024 done SHALL be asserted only on the transition edge into DONE, never while remaining in DONE.

Reset
REQ-025 While clear_b=0, regardless of clk, outputs SHALL be:
  - count=00
  - busy=0
  - done=0
  - err=0
  - state=IDLE
REQ-026 The response to clear_b asserting SHALL be immediate, without waiting for a clock edge.
REQ-027 Reset asserted mid-count SHALL abort the countdown; no done pulse is generated.
REQ-028 After clear_b deasserts, the first rising edge SHALL obey REQ-015..REQ-021 normally.

Verification
REQ-029 Valid load, then enable held:
  - Stimulus: load seg_hi=79, seg_lo=24 (value 12), then enable=1 continuously.
  - Response: count goes 12 -> 11 -> … -> 01 -> 00.
  - busy is high throughout the count.
  - done pulses on the edge where count reaches 00, 18 edges after the load edge.
  - busy drops on that same edge.
REQ-030 Invalid low digit:
  - Stimulus: load with seg_lo=7F, seg_hi=40.
  - Response: err=1, busy=0, done=0, and count unchanged.
  - A following valid load of seg_hi=40, seg_lo=79 clears err and gives count=01.
REQ-031 Reload mid-count, then pause:
  - Stimulus: during COUNT at count=05, assert load=1 and enable=1 together with seg_hi=0E, seg_lo=0E.
  - Response: count=FF on the next edge, with no decrement on that edge.
  - Enable low for 3 edges then holds count=FF.
REQ-032 Zero load:
  - Stimulus: load seg_hi=40, seg_lo=40.
  - Response: one-cycle done pulse, count=00, busy=0.
  - Further enable pulses leave count=00 (no wrap to FF).
REQ-033 Asynchronous reset mid-count:
  - Stimulus: drop clear_b between clock edges while count=80.
  - Response: count=00, busy=0 and err=0 immediately, with no done pulse.
REQ-034 Decode sweep:
  - Stimulus: load every table entry on seg_lo with seg_hi=40.
  - Response: count = 00..0F in table order, and err stays 0.
